// File: rtl/param_wb_cache.sv
// Parametrised write-back, write-allocate, set-associative data cache (1 or 2 ways, true LRU).
// Misses evict through a block-wide memory port with a req/done handshake on both sides.
module param_wb_cache #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 4,
  parameter int WAYS            = 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              cpu_req,
  input  logic                              cpu_rw,
  input  logic [ADDR_W-1:0]                 cpu_addr,
  input  logic [DATA_W-1:0]                 cpu_wdata,
  output logic                              cpu_ready,
  output logic                              cpu_done,
  output logic [DATA_W-1:0]                 cpu_rdata,
  output logic                              hit_miss,
  output logic                              mem_req,
  output logic                              mem_rw,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_wdata,
  input  logic [DATA_W*WORDS_PER_BLOCK-1:0] mem_rdata,
  input  logic                              mem_done
);

  localparam int WO_BITS = $clog2(WORDS_PER_BLOCK);
  localparam int IX_BITS = $clog2(NUM_SETS);
  localparam int WO_W    = (WO_BITS > 0) ? WO_BITS : 1;
  localparam int IX_W    = (IX_BITS > 0) ? IX_BITS : 1;
  localparam int IX_LSB  = 2 + WO_BITS;
  localparam int TAG_LSB = IX_LSB + IX_BITS;
  localparam int TAG_W   = ADDR_W - TAG_LSB;
  localparam int BLK_W   = DATA_W * WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOOKUP    = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_e;

  state_e                         state_r;
  state_e                         next_state_s;
  logic                           req_rw_r;
  logic [ADDR_W-1:0]              req_addr_r;
  logic [DATA_W-1:0]              req_wdata_r;
  logic                           miss_flag_r;
  logic                           victim_r;
  logic                           gap_r;
  logic [DATA_W-1:0]              rdata_hold_r;

  logic [NUM_SETS-1:0][WAYS-1:0]  valid_r;
  logic [NUM_SETS-1:0][WAYS-1:0]  dirty_r;
  logic [NUM_SETS-1:0]            lru_r;
  logic [TAG_W-1:0]               tag_r  [NUM_SETS][WAYS];
  logic [BLK_W-1:0]               data_r [NUM_SETS][WAYS];

  logic [WO_W-1:0]                req_word_s;
  logic [IX_W-1:0]                req_index_s;
  logic [TAG_W-1:0]               req_tag_s;
  logic [1:0]                     match_s;
  logic [1:0]                     valid_pad_s;
  logic                           hit_s;
  logic                           hit_way_s;
  logic                           victim_s;
  logic                           victim_wb_s;
  logic [BLK_W-1:0]               hit_blk_s;
  logic [DATA_W-1:0]              rd_word_s;
  logic                           done_s;
  logic                           mem_req_s;
  logic                           mem_rw_s;
  logic                           mem_take_s;
  logic [ADDR_W-1:0]              mem_addr_s;
  logic [BLK_W-1:0]               mem_wdata_s;

  function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IX_W-1:0]  idx);
    block_addr = (ADDR_W'(tag) << TAG_LSB) |
                 ((ADDR_W'(idx) & ADDR_W'(NUM_SETS - 1)) << IX_LSB);
  endfunction

  function automatic logic [DATA_W-1:0] pick_word(input logic [BLK_W-1:0] blk,
                                                  input logic [WO_W-1:0]  w);
    pick_word = DATA_W'(blk >> (int'(w) * DATA_W));
  endfunction

  function automatic logic [BLK_W-1:0] merge_word(input logic [BLK_W-1:0]  blk,
                                                  input logic [WO_W-1:0]   w,
                                                  input logic [DATA_W-1:0] d);
    logic [BLK_W-1:0] mask;
    mask       = BLK_W'({DATA_W{1'b1}}) << (int'(w) * DATA_W);
    merge_word = (blk & ~mask) | (BLK_W'(d) << (int'(w) * DATA_W));
  endfunction

  assign req_word_s  = WO_W'((req_addr_r >> 2) & ADDR_W'(WORDS_PER_BLOCK - 1));
  assign req_index_s = IX_W'((req_addr_r >> IX_LSB) & ADDR_W'(NUM_SETS - 1));
  assign req_tag_s   = TAG_W'(req_addr_r >> TAG_LSB);

  // Tag compare and victim choice; missing second way reads as a valid non-match
  always_comb begin
    match_s     = 2'b00;
    valid_pad_s = 2'b11;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w]     = valid_r[req_index_s][w] && (tag_r[req_index_s][w] == req_tag_s);
      valid_pad_s[w] = valid_r[req_index_s][w];
    end
    hit_s       = |match_s;
    hit_way_s   = match_s[1];
    victim_s    = (!valid_pad_s[0]) ? 1'b0 : ((!valid_pad_s[1]) ? 1'b1 : lru_r[req_index_s]);
    victim_wb_s = valid_r[req_index_s][victim_s] && dirty_r[req_index_s][victim_s];
    hit_blk_s   = data_r[req_index_s][hit_way_s];
    rd_word_s   = pick_word(hit_blk_s, req_word_s);
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state_s = state_r;
    done_s       = 1'b0;
    mem_req_s    = 1'b0;
    mem_rw_s     = 1'b0;
    mem_addr_s   = '0;
    mem_wdata_s  = '0;
    case (state_r)
      ST_IDLE: begin
        if (cpu_req) begin
          next_state_s = ST_LOOKUP;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          done_s       = 1'b1;
          next_state_s = ST_IDLE;
        end else if (victim_wb_s) begin
          next_state_s = ST_WRITEBACK;
        end else begin
          next_state_s = ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        mem_req_s   = 1'b1;
        mem_rw_s    = 1'b1;
        mem_addr_s  = block_addr(tag_r[req_index_s][victim_r], req_index_s);
        mem_wdata_s = data_r[req_index_s][victim_r];
        if (mem_done) begin
          next_state_s = ST_ALLOCATE;
        end else begin
          next_state_s = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        // gap_r holds mem_req low for one cycle after a write-back completes
        mem_req_s  = ~gap_r;
        mem_addr_s = block_addr(req_tag_s, req_index_s);
        if (mem_done && !gap_r) begin
          next_state_s = ST_LOOKUP;
        end else begin
          next_state_s = ST_ALLOCATE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    mem_take_s = mem_done && mem_req_s;
  end

  // State, request latch and per-line valid/dirty/LRU bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      req_rw_r     <= 1'b0;
      req_addr_r   <= '0;
      req_wdata_r  <= '0;
      miss_flag_r  <= 1'b0;
      victim_r     <= 1'b0;
      gap_r        <= 1'b0;
      rdata_hold_r <= '0;
      valid_r      <= '0;
      dirty_r      <= '0;
      lru_r        <= '0;
    end else begin
      state_r <= next_state_s;
      gap_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cpu_req) begin
            req_rw_r    <= cpu_rw;
            req_addr_r  <= cpu_addr;
            req_wdata_r <= cpu_wdata;
            miss_flag_r <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          if (hit_s) begin
            rdata_hold_r        <= rd_word_s;
            lru_r[req_index_s]  <= (WAYS == 2) ? ~hit_way_s : 1'b0;
            if (req_rw_r) begin
              dirty_r[req_index_s][hit_way_s] <= 1'b1;
            end
          end else begin
            miss_flag_r <= 1'b1;
            victim_r    <= victim_s;
          end
        end
        ST_WRITEBACK: begin
          if (mem_take_s) begin
            dirty_r[req_index_s][victim_r] <= 1'b0;
            gap_r                          <= 1'b1;
          end
        end
        ST_ALLOCATE: begin
          if (mem_take_s) begin
            valid_r[req_index_s][victim_r] <= 1'b1;
            dirty_r[req_index_s][victim_r] <= 1'b0;
          end
        end
        default: begin
          gap_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage; contents are don't-care until the valid bit is set
  always_ff @(posedge clock) begin
    if ((state_r == ST_LOOKUP) && hit_s && req_rw_r) begin
      data_r[req_index_s][hit_way_s] <= merge_word(hit_blk_s, req_word_s, req_wdata_r);
    end
    if ((state_r == ST_ALLOCATE) && mem_take_s) begin
      data_r[req_index_s][victim_r] <= mem_rdata;
      tag_r[req_index_s][victim_r]  <= req_tag_s;
    end
  end

  assign cpu_ready = (state_r == ST_IDLE);
  assign cpu_done  = done_s;
  assign cpu_rdata = done_s ? rd_word_s : rdata_hold_r;
  assign hit_miss  = done_s & ~miss_flag_r;
  assign mem_req   = mem_req_s;
  assign mem_rw    = mem_rw_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_param_wb_cache.sv
// Self-checking bench for param_wb_cache: directed vector table, multi-cycle corner sequences,
// randomized traffic against an LRU-queue reference model, and a direct-mapped instance.
module tb_param_wb_cache;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         cpu_req, cpu_rw;
  logic [9:0]   cpu_addr;
  logic [31:0]  cpu_wdata;
  logic         cpu_ready, cpu_done, hit_miss;
  logic [31:0]  cpu_rdata;
  logic         mem_req, mem_rw, mem_done_m, stray_done, mem_done;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata, mem_rdata;

  logic         d_req, d_ready, d_done, d_hm, d_mem_req, d_mem_rw, d_mem_done;
  logic [9:0]   d_addr, d_mem_addr;
  logic [31:0]  d_rdata;
  logic [127:0] d_mem_wdata, d_mem_rdata;

  int compared = 0;
  int mismatched = 0;

  always #5 clock = ~clock;
  assign mem_done = mem_done_m | stray_done;

  param_wb_cache dut (
    .clock(clock), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata), .hit_miss(hit_miss), .mem_req(mem_req), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done)
  );

  param_wb_cache #(.WAYS(1), .NUM_SETS(8)) dut_dm (
    .clock(clock), .reset_n(reset_n), .cpu_req(d_req), .cpu_rw(1'b0),
    .cpu_addr(d_addr), .cpu_wdata(32'h0), .cpu_ready(d_ready), .cpu_done(d_done),
    .cpu_rdata(d_rdata), .hit_miss(d_hm), .mem_req(d_mem_req), .mem_rw(d_mem_rw),
    .mem_addr(d_mem_addr), .mem_wdata(d_mem_wdata), .mem_rdata(d_mem_rdata), .mem_done(d_mem_done)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- main memory model (word at byte address A = A) ----------------
  logic [31:0]  store [256];
  int           wb_cnt = 0, al_cnt = 0;
  logic [9:0]   last_wb_addr, last_al_addr;
  logic [127:0] last_wb_data;
  bit           slow = 0, rand_lat = 0, m_busy = 0;
  int           m_wait;
  logic         m_rw;
  logic [9:0]   m_addr;
  logic [127:0] m_wdata;

  always @(negedge clock) begin
    if (!reset_n || !mem_req) begin
      m_busy     = 0;
      mem_done_m = 1'b0;
    end else if (!m_busy) begin
      m_busy  = 1;
      m_wait  = slow ? 6 : (rand_lat ? int'($urandom_range(1, 3)) : 2);
      m_rw    = mem_rw;
      m_addr  = mem_addr;
      m_wdata = mem_wdata;
    end else if (!mem_done_m) begin
      chk("mem_rw_stable", mem_rw, m_rw);
      chk("mem_addr_stable", mem_addr, m_addr);
      if (m_rw) chk("mem_wdata_stable", mem_wdata, m_wdata);
      m_wait--;
      if (m_wait == 0) begin
        if (m_rw) begin
          for (int k = 0; k < 4; k++) store[int'(m_addr >> 2) + k] = m_wdata[32*k +: 32];
          wb_cnt++;
          last_wb_addr = m_addr;
          last_wb_data = m_wdata;
        end else begin
          for (int k = 0; k < 4; k++) mem_rdata[32*k +: 32] = store[int'(m_addr >> 2) + k];
          al_cnt++;
          last_al_addr = m_addr;
        end
        mem_done_m = 1'b1;
      end
    end else begin
      chk("mem_req_dropped_after_done", mem_req, 1'b0);
    end
  end

  // direct-mapped instance memory: read-only, latency 2
  int d_al_cnt = 0, d_wait;
  bit d_busy = 0;
  always @(negedge clock) begin
    if (!reset_n || !d_mem_req) begin
      d_busy     = 0;
      d_mem_done = 1'b0;
    end else if (!d_busy) begin
      d_busy = 1;
      d_wait = 2;
    end else if (!d_mem_done) begin
      d_wait--;
      if (d_wait == 0) begin
        for (int k = 0; k < 4; k++) d_mem_rdata[32*k +: 32] = 32'(d_mem_addr) + 32'(4 * k);
        d_al_cnt++;
        d_mem_done = 1'b1;
      end
    end
  end

  // ---------------- reference model: per-set residency list, index 0 = least recent ----------------
  int          rs_blk [4][2];
  int          rs_cnt [4];
  bit          blk_dirty [64];
  logic [31:0] ref_mem [256];

  task automatic model_reset();
    for (int s = 0; s < 4; s++) rs_cnt[s] = 0;
    for (int b = 0; b < 64; b++) blk_dirty[b] = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = store[i];
  endtask

  task automatic model_access(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                              output bit e_hit, output bit e_wb, output logic [9:0] e_wba,
                              output logic [31:0] e_rd);
    int blk, set, pos, v;
    blk = int'(a >> 4);
    set = blk % 4;
    pos = -1;
    for (int i = 0; i < rs_cnt[set]; i++) if (rs_blk[set][i] == blk) pos = i;
    e_hit = (pos >= 0);
    e_wb  = 0;
    e_wba = 10'h000;
    if (!e_hit) begin
      if (rs_cnt[set] == 2) begin
        v = rs_blk[set][0];
        e_wb = blk_dirty[v];
        e_wba = 10'(v * 16);
        blk_dirty[v] = 0;
        rs_blk[set][0] = rs_blk[set][1];
        rs_cnt[set] = 1;
      end
      rs_blk[set][rs_cnt[set]] = blk;
      rs_cnt[set]++;
    end else begin
      for (int i = pos; i < rs_cnt[set] - 1; i++) rs_blk[set][i] = rs_blk[set][i+1];
      rs_blk[set][rs_cnt[set]-1] = blk;
    end
    if (rw) begin
      ref_mem[int'(a >> 2)] = wd;
      blk_dirty[blk] = 1;
    end
    e_rd = ref_mem[int'(a >> 2)];
  endtask

  // ---------------- CPU-side driver ----------------
  task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] wd, input int pulse_at,
                        output logic [31:0] rd, output logic hm, output int lat, output bit got);
    @(negedge clock);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = wd;
    got = 0; lat = 0; rd = 32'h0; hm = 1'b0;
    for (int i = 1; i <= 200 && !got; i++) begin
      @(negedge clock);
      cpu_req = (i == pulse_at);
      if (i == pulse_at) begin
        cpu_addr = 10'h3F0; cpu_rw = 1'b0;
      end
      if (cpu_done) begin
        got = 1; rd = cpu_rdata; hm = hit_miss; lat = i;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic apply(input logic rw, input logic [9:0] a, input logic [31:0] wd, input int pulse_at,
                       input logic e_hm, input logic [31:0] e_rd, input logic e_wb,
                       input logic [9:0] e_wba, input logic e_al);
    logic [31:0] rd;
    logic        hm;
    int          lat, wb0, al0;
    bit          got;
    wb0 = wb_cnt; al0 = al_cnt;
    access(rw, a, wd, pulse_at, rd, hm, lat, got);
    chk("cpu_done_seen", got, 1'b1);
    if (got) begin
      chk("hit_miss", hm, e_hm);
      if (!rw) chk("cpu_rdata", rd, e_rd);
      chk("writeback_count", wb_cnt - wb0, e_wb);
      if (e_wb) chk("writeback_addr", last_wb_addr, e_wba);
      chk("allocate_count", al_cnt - al0, e_al);
      if (e_al) chk("allocate_addr", last_al_addr, a & 10'h3F0);
      if (e_hm) chk("hit_latency", lat, 1);
      if (pulse_at > 0) begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clock);
          chk("no_extra_done", cpu_done, 1'b0);
          chk("ready_after_done", cpu_ready, 1'b1);
        end
      end
    end
  endtask

  task automatic model_apply(input logic rw, input logic [9:0] a, input logic [31:0] wd, input int pulse_at);
    bit e_hit, e_wb;
    logic [9:0] e_wba;
    logic [31:0] e_rd;
    model_access(rw, a, wd, e_hit, e_wb, e_wba, e_rd);
    apply(rw, a, wd, pulse_at, e_hit, e_rd, e_wb, e_wba, !e_hit);
  endtask

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        exp_hm;
    logic [31:0] exp_rd;
    logic        exp_wb;
    logic [9:0]  exp_wb_addr;
    logic        exp_al;
  } vec_t;

  vec_t        vecs [8];
  logic [9:0]  d_list [4];
  logic        d_hm_exp [4];

  initial begin
    bit mh, mw; logic [9:0] ma; logic [31:0] mr;
    bit seen;

    vecs[0] = '{1'b0, 10'h000, 32'h0,        1'b0, 32'h0000_0000, 1'b0, 10'h000, 1'b1};
    vecs[1] = '{1'b0, 10'h004, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 10'h000, 1'b0};
    vecs[2] = '{1'b1, 10'h008, 32'hDEADBEEF, 1'b1, 32'h0,         1'b0, 10'h000, 1'b0};
    vecs[3] = '{1'b0, 10'h008, 32'h0,        1'b1, 32'hDEADBEEF,  1'b0, 10'h000, 1'b0};
    vecs[4] = '{1'b0, 10'h040, 32'h0,        1'b0, 32'h0000_0040, 1'b0, 10'h000, 1'b1};
    vecs[5] = '{1'b0, 10'h000, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 10'h000, 1'b0};
    vecs[6] = '{1'b0, 10'h080, 32'h0,        1'b0, 32'h0000_0080, 1'b0, 10'h000, 1'b1};
    vecs[7] = '{1'b0, 10'h0C0, 32'h0,        1'b0, 32'h0000_00C0, 1'b1, 10'h000, 1'b1};
    d_list[0] = 10'h000; d_list[1] = 10'h080; d_list[2] = 10'h000; d_list[3] = 10'h004;
    d_hm_exp[0] = 1'b0;  d_hm_exp[1] = 1'b0;  d_hm_exp[2] = 1'b0;  d_hm_exp[3] = 1'b1;

    for (int i = 0; i < 256; i++) store[i] = 32'(i * 4);
    reset_n = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 10'h0; cpu_wdata = 32'h0;
    stray_done = 1'b0; mem_rdata = '0; d_req = 1'b0; d_addr = 10'h0; d_mem_rdata = '0;
    mem_done_m = 1'b0; d_mem_done = 1'b0;

    // reset state
    repeat (3) @(negedge clock);
    chk("reset_cpu_ready", cpu_ready, 1'b1);
    chk("reset_cpu_done", cpu_done, 1'b0);
    chk("reset_cpu_rdata", cpu_rdata, 32'h0);
    chk("reset_hit_miss", hit_miss, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);
    reset_n = 1'b1;
    model_reset();

    // scenarios 1-3 as a vector table
    for (int v = 0; v < 8; v++) begin
      model_access(vecs[v].rw, vecs[v].addr, vecs[v].wdata, mh, mw, ma, mr);
      apply(vecs[v].rw, vecs[v].addr, vecs[v].wdata, 0, vecs[v].exp_hm, vecs[v].exp_rd,
            vecs[v].exp_wb, vecs[v].exp_wb_addr, vecs[v].exp_al);
    end
    chk("evicted_word2", last_wb_data[95:64], 32'hDEADBEEF);

    // scenario 4: reset while waiting on a block fetch
    @(negedge clock);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h000;
    @(negedge clock);
    cpu_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req && !mem_rw) seen = 1;
      else @(negedge clock);
    end
    chk("allocate_reached", seen, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_mem_req", mem_req, 1'b0);
    chk("midreset_cpu_ready", cpu_ready, 1'b1);
    chk("midreset_cpu_done", cpu_done, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    @(negedge clock); stray_done = 1'b1;
    @(negedge clock); stray_done = 1'b0;
    chk("stray_done_ready", cpu_ready, 1'b1);
    chk("stray_done_mem_req", mem_req, 1'b0);
    model_apply(1'b0, 10'h000, 32'h0, 0);

    // scenario 5: slow memory, stray CPU pulses during the wait
    slow = 1;
    model_apply(1'b1, 10'h104, 32'h1234_5678, 3);
    model_apply(1'b0, 10'h140, 32'h0, 0);
    model_apply(1'b0, 10'h180, 32'h0, 4);
    slow = 0;

    // randomized traffic with variable memory latency
    rand_lat = 1;
    for (int n = 0; n < 300; n++) begin
      model_apply(1'($urandom_range(0, 1)), 10'($urandom_range(0, 63) * 4), $urandom, 0);
    end
    rand_lat = 0;
    model_apply(1'b0, 10'h104, 32'h0, 0);

    // scenario 6: direct-mapped instance, conflicting blocks in set 0
    for (int j = 0; j < 4; j++) begin
      int  al0;
      bit  got;
      al0 = d_al_cnt;
      got = 0;
      @(negedge clock);
      d_req = 1'b1; d_addr = d_list[j];
      for (int i = 0; i < 50 && !got; i++) begin
        @(negedge clock);
        d_req = 1'b0;
        if (d_done) begin
          got = 1;
          chk("dm_hit_miss", d_hm, d_hm_exp[j]);
          chk("dm_rdata", d_rdata, 32'(d_list[j]));
        end
      end
      chk("dm_done_seen", got, 1'b1);
      chk("dm_allocate_count", d_al_cnt - al0, !d_hm_exp[j]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
